// File: rtl/sweep_result_collector.sv
// Sweep result collector: pairs modulus and phase results by frequency index, counts completed points, serves random-access readback.
// Latency: strobe to memory/points_done update 1 cycle; read port 1 cycle; CLEAR lasts np cycles.
// Backpressure: none; both write strobes and the read port are accepted every cycle.
//
// Optional feature macro: COLLECTOR_TIMEOUT_EN enables the COLLECT watchdog (TIMEOUT_CYCLES idle cycles -> DONE with timeout=1).
// Ports: clk125/areset_n; start/num_points sweep control; valid_m/modulo/addr_m and valid_p/phase/addr_p result streams;
//        rd_en/rd_addr -> rd_valid/rd_modulo/rd_phase/rd_complete readback; points_done/sweep_done/overrun_err/timeout status.
module sweep_result_collector #(
    parameter int ADDR_WIDTH     = 8,
    parameter int MOD_WIDTH      = 32,
    parameter int PH_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                  clk125,
    input  logic                  areset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_points,
    input  logic                  valid_m,
    input  logic [MOD_WIDTH-1:0]  modulo,
    input  logic [ADDR_WIDTH-1:0] addr_m,
    input  logic                  valid_p,
    input  logic [PH_WIDTH-1:0]   phase,
    input  logic [ADDR_WIDTH-1:0] addr_p,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [MOD_WIDTH-1:0]  rd_modulo,
    output logic [PH_WIDTH-1:0]   rd_phase,
    output logic                  rd_complete,
    output logic [ADDR_WIDTH:0]   points_done,
    output logic                  sweep_done,
    output logic                  overrun_err,
    output logic                  timeout
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COLLECT, S_DONE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          np_q;
    logic [CW-1:0]          points_done_q;
    logic [CW-1:0]          points_done_d;
    logic [ADDR_WIDTH-1:0]  clr_idx_q;
    logic [DEPTH-1:0]       m_bits_q;
    logic [DEPTH-1:0]       p_bits_q;
    logic                   sweep_done_q;
    logic                   overrun_q;
    logic                   timeout_q;

    logic [MOD_WIDTH-1:0]   mod_mem [DEPTH];
    logic [PH_WIDTH-1:0]    ph_mem  [DEPTH];

    logic                   rd_valid_q;
    logic [MOD_WIDTH-1:0]   rd_modulo_q;
    logic [PH_WIDTH-1:0]    rd_phase_q;
    logic                   rd_complete_q;

    logic                   m_in_rng, p_in_rng, m_new, p_new, comp_m, comp_p;
    logic [1:0]             n_comp;
    logic                   tmo_hit;

    // A point completes when its second flag is set; a same-cycle pair to
    // one new index must count once, two different completions count twice.
    always_comb begin
        m_in_rng = valid_m && ({1'b0, addr_m} < np_q);
        p_in_rng = valid_p && ({1'b0, addr_p} < np_q);
        m_new    = m_in_rng && !m_bits_q[addr_m];
        p_new    = p_in_rng && !p_bits_q[addr_p];
        comp_m   = m_new && (p_bits_q[addr_m] || (p_new && (addr_p == addr_m)));
        comp_p   = p_new && (m_bits_q[addr_p] || (m_new && (addr_m == addr_p)));
        n_comp   = {1'b0, comp_m} + {1'b0, comp_p};
        if (comp_m && comp_p && (addr_m == addr_p)) begin
            n_comp = 2'd1;
        end
        points_done_d = points_done_q + {{(CW-2){1'b0}}, n_comp};
    end

`ifdef COLLECTOR_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    // Counts idle COLLECT cycles; held at zero outside COLLECT so it starts fresh on entry.
    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != S_COLLECT || valid_m || valid_p) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
    end

    assign tmo_hit = !(valid_m || valid_p) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            state_q       <= S_IDLE;
            np_q          <= '0;
            points_done_q <= '0;
            clr_idx_q     <= '0;
            m_bits_q      <= '0;
            p_bits_q      <= '0;
            sweep_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        np_q          <= (num_points == '0) ? CW'(DEPTH) : {1'b0, num_points};
                        clr_idx_q     <= '0;
                        points_done_q <= '0;
                        overrun_q     <= 1'b0;
                        timeout_q     <= 1'b0;
                        state_q       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    m_bits_q[clr_idx_q] <= 1'b0;
                    p_bits_q[clr_idx_q] <= 1'b0;
                    clr_idx_q           <= clr_idx_q + 1'b1;
                    if (valid_m || valid_p) begin
                        overrun_q <= 1'b1;
                    end
                    if (!start) begin
                        state_q <= S_IDLE;
                    end else if ({1'b0, clr_idx_q} == np_q - 1'b1) begin
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (m_in_rng) m_bits_q[addr_m] <= 1'b1;
                    if (p_in_rng) p_bits_q[addr_p] <= 1'b1;
                    // Any strobe that is not a new in-range point is out-of-range or a duplicate.
                    if ((valid_m && !m_new) || (valid_p && !p_new)) begin
                        overrun_q <= 1'b1;
                    end
                    points_done_q <= points_done_d;
                    if (!start) begin
                        state_q <= S_IDLE;
                    end else if (points_done_d == np_q) begin
                        sweep_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (tmo_hit) begin
                        timeout_q    <= 1'b1;
                        sweep_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                default: begin
                    if (!start) begin
                        sweep_done_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Result memories: zeroed during CLEAR, written only in COLLECT for in-range indices.
    always_ff @(posedge clk125) begin
        if (state_q == S_CLEAR) begin
            mod_mem[clr_idx_q] <= '0;
            ph_mem[clr_idx_q]  <= '0;
        end else if (state_q == S_COLLECT) begin
            if (m_in_rng) mod_mem[addr_m] <= modulo;
            if (p_in_rng) ph_mem[addr_p]  <= phase;
        end
    end

    // Registered read port; a same-address write in the same cycle returns the old data.
    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            rd_valid_q    <= 1'b0;
            rd_modulo_q   <= '0;
            rd_phase_q    <= '0;
            rd_complete_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_modulo_q   <= mod_mem[rd_addr];
                rd_phase_q    <= ph_mem[rd_addr];
                rd_complete_q <= m_bits_q[rd_addr] & p_bits_q[rd_addr];
            end
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_modulo   = rd_modulo_q;
    assign rd_phase    = rd_phase_q;
    assign rd_complete = rd_complete_q;
    assign points_done = points_done_q;
    assign sweep_done  = sweep_done_q;
    assign overrun_err = overrun_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_sweep_result_collector.sv
// Testbench for sweep_result_collector: directed sweeps with random data/ordering checked against a set-based model.
// Latency: inputs driven #1 after the clock edge, outputs sampled #1 after the following edge.
// Backpressure: none exercised; the DUT accepts every strobe.
module tb_sweep_result_collector;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int TMO   = 100;

    logic          clk125 = 1'b0;
    logic          areset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_points = '0;
    logic          valid_m = 1'b0;
    logic [31:0]   modulo = '0;
    logic [AW-1:0] addr_m = '0;
    logic          valid_p = 1'b0;
    logic [31:0]   phase = '0;
    logic [AW-1:0] addr_p = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [31:0]   rd_modulo;
    logic [31:0]   rd_phase;
    logic          rd_complete;
    logic [AW:0]   points_done;
    logic          sweep_done;
    logic          overrun_err;
    logic          timeout;

    always #4 clk125 = ~clk125;

    sweep_result_collector #(
        .ADDR_WIDTH(AW), .MOD_WIDTH(32), .PH_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk125(clk125), .areset_n(areset_n), .start(start), .num_points(num_points),
        .valid_m(valid_m), .modulo(modulo), .addr_m(addr_m),
        .valid_p(valid_p), .phase(phase), .addr_p(addr_p),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_modulo(rd_modulo),
        .rd_phase(rd_phase), .rd_complete(rd_complete), .points_done(points_done),
        .sweep_done(sweep_done), .overrun_err(overrun_err), .timeout(timeout)
    );

    // Reference model: stored values and presence sets per index, plus sweep status.
    logic [31:0] ref_m [DEPTH];
    logic [31:0] ref_p [DEPTH];
    bit          hm [DEPTH];
    bit          hp [DEPTH];
    int          np_m = 0;
    int          mode = 0;      // 0 idle, 1 collecting, 2 done, 3 clearing
    int          idle_cnt = 0;
    bit          ovr_e = 0, sweep_e = 0, tmo_e = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pts();
        int c = 0;
        for (int i = 0; i < np_m; i++) if (hm[i] && hp[i]) c++;
        return c;
    endfunction

    task automatic step();
        @(posedge clk125);
        #1;
    endtask

    // One clock cycle with optional strobes and read; checks all status outputs afterwards.
    task automatic cyc(input bit vm, input int am, input logic [31:0] dm,
                       input bit vp, input int ap, input logic [31:0] dp,
                       input bit re, input int ra);
        logic [31:0] em, ep;
        bit          ec;
        valid_m = vm; addr_m = am[AW-1:0]; modulo = dm;
        valid_p = vp; addr_p = ap[AW-1:0]; phase  = dp;
        rd_en   = re; rd_addr = ra[AW-1:0];
        em = ref_m[ra]; ep = ref_p[ra]; ec = hm[ra] && hp[ra];
        step();
        valid_m = 1'b0; valid_p = 1'b0; rd_en = 1'b0;
        if (mode == 1) begin
            if (vm) begin
                if (am >= np_m) ovr_e = 1;
                else begin ref_m[am] = dm; if (hm[am]) ovr_e = 1; hm[am] = 1; end
            end
            if (vp) begin
                if (ap >= np_m) ovr_e = 1;
                else begin ref_p[ap] = dp; if (hp[ap]) ovr_e = 1; hp[ap] = 1; end
            end
            if (vm || vp) idle_cnt = 0; else idle_cnt++;
            if (pts() == np_m) begin mode = 2; sweep_e = 1; end
`ifdef COLLECTOR_TIMEOUT_EN
            else if (idle_cnt == TMO) begin mode = 2; sweep_e = 1; tmo_e = 1; end
`endif
        end
        chk("rd_valid", rd_valid, re);
        if (re) begin
            chk("rd_modulo", rd_modulo, em);
            chk("rd_phase", rd_phase, ep);
            chk("rd_complete", rd_complete, ec);
        end
        chk("points_done", points_done, pts());
        chk("sweep_done", sweep_done, sweep_e);
        chk("overrun_err", overrun_err, ovr_e);
        chk("timeout", timeout, tmo_e);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Start a sweep and sit through CLEAR; optionally strobe in the last CLEAR cycle.
    task automatic do_start(input int np, input bit probe);
        num_points = np[AW-1:0];
        start = 1'b1;
        step();
        np_m = (np == 0) ? DEPTH : np;
        for (int i = 0; i < np_m; i++) begin hm[i] = 0; hp[i] = 0; ref_m[i] = 0; ref_p[i] = 0; end
        ovr_e = 0; tmo_e = 0; sweep_e = 0; mode = 3;
        chk("clear_points", points_done, 0);
        chk("clear_overrun", overrun_err, 0);
        for (int i = 0; i < np_m; i++) begin
            if (probe && i == np_m - 1) begin valid_m = 1'b1; addr_m = '0; modulo = 32'hDEAD_BEEF; end
            step();
            valid_m = 1'b0;
        end
        if (probe) ovr_e = 1;
        chk("clear_end_overrun", overrun_err, ovr_e);
        mode = 1; idle_cnt = 0;
    endtask

    task automatic stop();
        start = 1'b0;
        step();
        mode = 0; sweep_e = 0;
        chk("stop_sweep_done", sweep_done, 0);
    endtask

    task automatic mk_perm(input int n, output int q[$]);
        int t, j;
        q = {};
        for (int i = 0; i < n; i++) q.push_back(i);
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(i);
            t = q[i]; q[i] = q[j]; q[j] = t;
        end
    endtask

    initial begin
        int pm[$], pp[$];
        int am, ap, guard, np;
        bit vm, vp;

        // Reset state
        #20;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_points", points_done, 0);
        chk("rst_sweep", sweep_done, 0);
        chk("rst_overrun", overrun_err, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rd_complete", rd_complete, 0);
        @(negedge clk125);
        areset_n = 1'b1;
        step();

        // num_points=0: full-depth sweep in random order on both streams
        do_start(0, 0);
        mk_perm(DEPTH, pm);
        mk_perm(DEPTH, pp);
        guard = 0;
        while ((pm.size() > 0 || pp.size() > 0) && guard < 2000) begin
            vm = (pm.size() > 0) && ($urandom_range(3) != 0);
            vp = (pp.size() > 0) && ($urandom_range(3) != 0);
            am = vm ? pm.pop_front() : 0;
            ap = vp ? pp.pop_front() : 0;
            cyc(vm, am, $urandom, vp, ap, $urandom, $urandom_range(1), $urandom_range(DEPTH - 1));
            guard++;
        end
        chk("np0_done", sweep_done, 1);
        stop();

        // np=4: modulus in order, phase reversed; strobe in last CLEAR cycle is dropped
        do_start(4, 1);
        for (int i = 0; i < 4; i++) cyc(1, i, $urandom, 0, 0, 0, 1, i);
        for (int i = 3; i >= 0; i--) cyc(0, 0, 0, 1, i, $urandom, 1, i);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, i);
        idle_cyc();
        stop();

        // Same-cycle strobes to the last missing index
        do_start(4, 0);
        cyc(1, 0, $urandom, 0, 0, 0, 0, 0);
        cyc(1, 1, $urandom, 0, 0, 0, 0, 0);
        cyc(1, 3, $urandom, 1, 0, $urandom, 0, 0);
        cyc(0, 0, 0, 1, 1, $urandom, 0, 0);
        cyc(0, 0, 0, 1, 3, $urandom, 0, 0);
        cyc(1, 2, $urandom, 1, 2, $urandom, 1, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 2);
        stop();

        // Duplicate and out-of-range modulus
        do_start(4, 0);
        cyc(1, 1, $urandom, 0, 0, 0, 0, 0);
        cyc(1, 1, $urandom, 0, 0, 0, 0, 0);
        cyc(1, 9, 32'h55, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 9);
        for (int i = 0; i < 4; i++) cyc(i != 1, i, $urandom, 1, i, $urandom, 0, 0);
        stop();

        // Random sweeps with occasional duplicate/out-of-range strobes
        for (int r = 0; r < 6; r++) begin
            np = $urandom_range(12, 1);
            do_start(np, 0);
            mk_perm(np, pm);
            mk_perm(np, pp);
            guard = 0;
            while (mode == 1 && guard < 200) begin
                vm = ($urandom_range(3) != 0);
                vp = ($urandom_range(3) != 0);
                am = $urandom_range(15);
                ap = $urandom_range(15);
                if (vm && pm.size() > 0 && $urandom_range(9) != 0) am = pm.pop_front();
                if (vp && pp.size() > 0 && $urandom_range(9) != 0) ap = pp.pop_front();
                cyc(vm, am, $urandom, vp, ap, $urandom, $urandom_range(1), $urandom_range(15));
                guard++;
            end
            chk("rand_done", sweep_done, 1);
            stop();
        end

        // Abort mid-COLLECT, data retained, re-start clears
        do_start(4, 0);
        cyc(1, 0, $urandom, 1, 0, $urandom, 0, 0);
        cyc(1, 1, $urandom, 1, 1, $urandom, 0, 0);
        stop();
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        idle_cyc();
        do_start(4, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("restart_rd0", rd_modulo, 0);
        stop();

`ifdef COLLECTOR_TIMEOUT_EN
        // Watchdog: three points only, then silence
        do_start(4, 0);
        for (int i = 0; i < 3; i++) cyc(1, i, $urandom, 1, i, $urandom, 0, 0);
        for (int i = 0; i < TMO + 5; i++) idle_cyc();
        chk("tmo_flag", timeout, 1);
        chk("tmo_points", points_done, 3);
        stop();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sweep_result_collector.md
# sweep_result_collector

Collects the per-frequency results of the impedance sweep datapath and stores them for readout. It captures the modulus stream (valid_m/modulo/addr_m) and the phase stream (valid_p/phase/addr_p), which arrive independently and out of step. It pairs both results by frequency index in on-chip result memories and counts completed points. It raises sweep_done when every point of the sweep holds both results, and exposes a registered random-access read port to the processor bus bridge.

## Interface
- ADDR_WIDTH, 8, frequency index width; memory depth 2**ADDR_WIDTH
- MOD_WIDTH, 32, modulus word width
- PH_WIDTH, 32, phase word width (two's complement, stored raw)
- TIMEOUT_CYCLES, 2**24, watchdog limit; used only with COLLECTOR_TIMEOUT_EN
- clk125  in  1  system clock
- areset_n  in  1  asynchronous, active-low reset
- start  in  1  sweep request level, same signal that drives the upstream sweep controller
- num_points  in  ADDR_WIDTH  points in the sweep; 0 means 2**ADDR_WIDTH; sampled on the IDLE→CLEAR transition
- valid_m  in  1  one-cycle strobe, modulo/addr_m valid
- modulo  in  MOD_WIDTH  modulus result
- addr_m  in  ADDR_WIDTH  frequency index of modulo
- valid_p  in  1  one-cycle strobe, phase/addr_p valid
- phase  in  PH_WIDTH  phase result
- addr_p  in  ADDR_WIDTH  frequency index of phase
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read index
- rd_valid  out  1  read data valid, one cycle after rd_en
- rd_modulo  out  MOD_WIDTH  stored modulus at rd_addr
- rd_phase  out  PH_WIDTH  stored phase at rd_addr
- rd_complete  out  1  both results present for rd_addr
- points_done  out  ADDR_WIDTH+1  count of completed points
- sweep_done  out  1  all points complete; held until start is low
- overrun_err  out  1  sticky error flag; cleared on entry to CLEAR
- timeout  out  1  watchdog expired (0 when the macro is undefined)

## Operation
- Reset values: all outputs 0; state IDLE; m_bits/p_bits (per-point presence flags) 0. Memory contents are undefined until the first CLEAR.
- IDLE: wait for start=1, then latch num_points into np (0→2**ADDR_WIDTH) and go to CLEAR.
- CLEAR: walk an index from 0 to np-1, one per cycle. At each index, zero both memories and clear m_bits/p_bits. Also clear points_done, overrun_err and timeout. After index np-1, go to COLLECT. Valid strobes arriving during CLEAR are dropped and set overrun_err.
- COLLECT, modulus path: on valid_m, check addr_m. If addr_m>=np, do not write; set overrun_err. Otherwise write modulo into mod_mem[addr_m]. If m_bits[addr_m] was already set, overwrite the data and set overrun_err without counting. If not, set the bit.
- COLLECT, phase path: same rules for valid_p, phase, ph_mem and p_bits.
- Completion: a point completes on the cycle its second flag is set; points_done increments by 1. If both strobes hit the same new index in the same cycle, increment once. If both strobes complete two different points in the same cycle, increment by 2.
- COLLECT→DONE when points_done==np; sweep_done=1 from that point.
- DONE: hold all data. When start=0, go to IDLE and clear sweep_done.
- Abort: start=0 in CLEAR or COLLECT → IDLE next cycle. sweep_done stays 0; partial data is retained.
- Read port: active in every state. On rd_en, register mod_mem[rd_addr], ph_mem[rd_addr] and m_bits&p_bits into the outputs the next cycle, with rd_valid=1 for one cycle. A read and a write to the same address in the same cycle return the old data.

## Timing
- Write strobe to memory update: 1 cycle. points_done updates on the same edge.
- sweep_done rises on the edge after the final completing strobe.
- CLEAR lasts exactly np cycles. start rising at cycle t puts the block in COLLECT at cycle t+1+np.
- Read latency is 1 cycle. Back-to-back reads are supported at full rate.
- Both write ports are accepted every cycle; there is no backpressure.

## Configuration
- COLLECTOR_TIMEOUT_EN defined: a counter clears on entry to COLLECT and on every accepted valid_m/valid_p, and increments otherwise. When it reaches TIMEOUT_CYCLES, set timeout=1, go to DONE, and assert sweep_done with points_done<np.
- Undefined: no counter is built, timeout is tied to 0, and COLLECT waits indefinitely.

## Test plan
- np=4; send modulo and phase for indices 0..3 in order, then reverse order on the phase stream → points_done steps 1..4, sweep_done=1 one cycle after the last strobe, reads return the written values with rd_complete=1.
- Same-cycle valid_m and valid_p to index 2 (np=4, others complete) → points_done increments once to 4, sweep_done=1.
- Duplicate modulo to index 1, then modulo 0x55 to index 9 with np=4 → index 1 holds the second value, index 9 is untouched, overrun_err=1, points_done unchanged.
- num_points=0 → CLEAR lasts 256 cycles; 256 full pairs are needed for sweep_done.
- start dropped mid-COLLECT after 2 points → IDLE, sweep_done=0; a new start re-clears, and reads of index 0 return 0 once CLEAR finishes.
- With COLLECTOR_TIMEOUT_EN and TIMEOUT_CYCLES=100, np=4, only 3 points sent → timeout=1 and sweep_done=1 100 cycles after the last strobe, points_done=3.
